return_stack: RTL and testbench
===============================

RETURN_STACK -- requirements
Module: return_stack

Interface
Parameters
REQ-001 SHALL have parameter DEPTH, default 8, meaning number of return-address entries (power of two, 2..16).
REQ-002 SHALL have parameter WIDTH, default 8, meaning address width in bits.
Ports
REQ-003 SHALL have port clock  input  1  system clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port push  input  1  subroutine call (BR.SUB): store return address.
REQ-006 SHALL have port pop  input  1  subroutine return: discard top entry.
REQ-007 SHALL have port pushAddr  input  WIDTH  return address to store (incremented PC).
REQ-008 SHALL have port clearErr  input  1  synchronous clear of sticky error flags.
REQ-009 SHALL have port topOut  output  WIDTH  current top-of-stack return address, combinational from state.
REQ-010 SHALL have port count  output  log2(DEPTH)+1  number of valid entries.
REQ-011 SHALL have port empty  output  1  high when count = 0.
REQ-012 SHALL have port full  output  1  high when count = DEPTH.
REQ-013 SHALL have port overflow  output  1  sticky: a push occurred while full.
REQ-014 SHALL have port underflow  output  1  sticky: a pop occurred while empty.

Function
REQ-015 SHALL store entries in a circular buffer indexed by a top pointer that wraps modulo DEPTH.
REQ-016 SHALL drive topOut = entry at top pointer when count > 0, else all zeros.
REQ-017 SHALL apply push/pop at the rising clock edge; new top visible on topOut in the following cycle (1-cycle latency).
REQ-018 Push only, not full: SHALL advance pointer, write pushAddr, count += 1.
REQ-019 Push only, full: SHALL advance pointer (wrap), overwrite oldest entry, count stays DEPTH, set overflow.
REQ-020 Pop only, not empty: SHALL retreat pointer (wrap), count -= 1; popped entry contents need not be cleared.
REQ-021 Pop only, empty: SHALL leave pointer and count unchanged, set underflow.
REQ-022 Push and pop same cycle, not empty: SHALL overwrite the top entry with pushAddr, pointer and count unchanged, no flag change (tail call).
REQ-023 Push and pop same cycle, empty: SHALL perform the push (count = 1, top = pushAddr) and set underflow.
REQ-024 Neither asserted: SHALL hold all state.
REQ-025 clearErr SHALL clear overflow and underflow at the edge; an error event in the same cycle SHALL take priority (flag ends set).
REQ-026 count SHALL never exceed DEPTH nor go below 0.

Reset
REQ-027 reset high SHALL immediately, without a clock edge, force pointer = 0, count = 0, overflow = 0, underflow = 0, so that topOut = 0, empty = 1, full = 0.
REQ-028 Entry storage need not be reset; topOut SHALL nevertheless read 0 while empty.
REQ-029 reset asserted mid-sequence SHALL discard all entries; push/pop are ignored while reset is high.

Verification
REQ-030 Reset, then push 0x11, 0x22, 0x33 -> topOut 0x33, count 3; pop x3 -> topOut 0x22, 0x11, then 0x00 with empty = 1.
REQ-031 DEPTH = 8: push 0x01..0x09 -> full = 1, overflow = 1, count 8, topOut 0x09; 8 pops return 0x09..0x02; 9th pop sets underflow.
REQ-032 From empty, pop -> underflow = 1, count 0; clearErr -> underflow = 0; clearErr with simultaneous empty pop -> underflow stays 1.
REQ-033 Stack [0x40, 0x50]; push 0x60 with pop in same cycle -> topOut 0x60, count 2; pop -> topOut 0x40.
REQ-034 Empty; push 0x7A with pop in same cycle -> count 1, topOut 0x7A, underflow = 1.
REQ-035 Push 0x10, 0x20, assert reset between clock edges -> count 0, topOut 0x00, flags 0 before the next edge.

Source files
------------

// File: rtl/return_stack.sv
// Subroutine return-address stack: circular buffer with a wrapping top pointer,
// overwrite-oldest on overflow and sticky overflow/underflow flags.
module return_stack #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         pushAddr,
   input  logic                     clearErr,
   output logic [WIDTH-1:0]         topOut,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full,
   output logic                     overflow,
   output logic                     underflow
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];

   logic [PW-1:0] ptr_reg, ptr_next, wr_idx;
   logic [CW-1:0] count_reg, count_next;
   logic          ovf_reg, ovf_next;
   logic          unf_reg, unf_next;
   logic          wr_en, set_ovf, set_unf;
   logic          is_empty, is_full;

   assign is_empty = (count_reg == '0);
   assign is_full  = (count_reg == FULL_COUNT);

   always_comb begin
      ptr_next   = ptr_reg;
      count_next = count_reg;
      wr_idx     = ptr_reg;
      wr_en      = 1'b0;
      set_ovf    = 1'b0;
      set_unf    = 1'b0;
      unique case ({push, pop})
         2'b10: begin
            // When full, advancing the pointer lands on the oldest entry,
            // so the write naturally overwrites it.
            ptr_next = ptr_reg + 1'b1;
            wr_idx   = ptr_reg + 1'b1;
            wr_en    = 1'b1;
            if (is_full)
               set_ovf = 1'b1;
            else
               count_next = count_reg + 1'b1;
         end
         2'b01: begin
            if (is_empty) begin
               set_unf = 1'b1;
            end else begin
               ptr_next   = ptr_reg - 1'b1;
               count_next = count_reg - 1'b1;
            end
         end
         2'b11: begin
            if (is_empty) begin
               ptr_next   = ptr_reg + 1'b1;
               wr_idx     = ptr_reg + 1'b1;
               count_next = CW'(1);
               set_unf    = 1'b1;
            end
            // Tail call: replace the top in place.
            wr_en = 1'b1;
         end
         default: ;
      endcase

      // A fresh error event wins over a simultaneous clear.
      ovf_next = set_ovf ? 1'b1 : (clearErr ? 1'b0 : ovf_reg);
      unf_next = set_unf ? 1'b1 : (clearErr ? 1'b0 : unf_reg);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ptr_reg   <= '0;
         count_reg <= '0;
         ovf_reg   <= 1'b0;
         unf_reg   <= 1'b0;
      end else begin
         ptr_reg   <= ptr_next;
         count_reg <= count_next;
         ovf_reg   <= ovf_next;
         unf_reg   <= unf_next;
      end
   end

   // Storage is not reset; an entry is only visible after it has been written.
   always_ff @(posedge clock) begin
      if (wr_en)
         mem[wr_idx] <= pushAddr;
   end

   assign topOut    = is_empty ? '0 : mem[ptr_reg];
   assign count     = count_reg;
   assign empty     = is_empty;
   assign full      = is_full;
   assign overflow  = ovf_reg;
   assign underflow = unf_reg;

endmodule

// File: tb/tb_return_stack.sv
// Directed bench for return_stack: call/return sequences, overflow wrap,
// underflow, tail calls, error clearing and asynchronous reset.
module tb_return_stack;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       push = 1'b0;
   logic       pop = 1'b0;
   logic [7:0] pushAddr = '0;
   logic       clearErr = 1'b0;
   logic [7:0] topOut;
   logic [3:0] count;
   logic       empty, full, overflow, underflow;

   int total = 0;
   int bad   = 0;

   return_stack #(.DEPTH(8), .WIDTH(8)) dut (
      .clock(clock), .reset(reset), .push(push), .pop(pop),
      .pushAddr(pushAddr), .clearErr(clearErr), .topOut(topOut),
      .count(count), .empty(empty), .full(full),
      .overflow(overflow), .underflow(underflow)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, obs);
      end
   endtask

   // One clock cycle with the given controls, sampled 1 time unit after the edge.
   task automatic op(input logic p, input logic q, input logic [7:0] a, input logic c);
      push = p; pop = q; pushAddr = a; clearErr = c;
      @(posedge clock);
      #1;
      push = 1'b0; pop = 1'b0; clearErr = 1'b0;
   endtask

   initial begin
      // reset state
      #12;
      chk("rst_top", 32'(topOut), 32'h0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_flags", {30'd0, overflow, underflow}, 32'd0);
      @(negedge clock);
      reset = 1'b0;

      // basic call/return
      op(1, 0, 8'h11, 0);
      chk("p1_top", 32'(topOut), 32'h11);
      op(1, 0, 8'h22, 0);
      op(1, 0, 8'h33, 0);
      chk("p3_top", 32'(topOut), 32'h33);
      chk("p3_count", 32'(count), 32'd3);
      op(0, 1, 8'h00, 0);
      chk("pop1_top", 32'(topOut), 32'h22);
      op(0, 1, 8'h00, 0);
      chk("pop2_top", 32'(topOut), 32'h11);
      op(0, 1, 8'h00, 0);
      chk("pop3_top", 32'(topOut), 32'h00);
      chk("pop3_empty", 32'(empty), 32'd1);
      chk("pop3_unf", 32'(underflow), 32'd0);

      // overflow with wrap: 0x01 is overwritten by 0x09
      for (int i = 1; i <= 9; i++) begin
         op(1, 0, 8'(i), 0);
         if (i == 8) begin
            chk("fill8_full", 32'(full), 32'd1);
            chk("fill8_ovf", 32'(overflow), 32'd0);
         end
      end
      chk("ovf_flag", 32'(overflow), 32'd1);
      chk("ovf_count", 32'(count), 32'd8);
      chk("ovf_top", 32'(topOut), 32'h09);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("drain_top%0d", i), 32'(topOut), 32'(9 - i));
         op(0, 1, 8'h00, 0);
      end
      chk("drain_empty", 32'(empty), 32'd1);
      chk("drain_unf", 32'(underflow), 32'd0);
      op(0, 1, 8'h00, 0);
      chk("drain9_unf", 32'(underflow), 32'd1);
      chk("drain9_count", 32'(count), 32'd0);
      op(0, 0, 8'h00, 1);
      chk("clr_flags", {30'd0, overflow, underflow}, 32'd0);

      // underflow and clear priority
      op(0, 1, 8'h00, 0);
      chk("unf_set", 32'(underflow), 32'd1);
      chk("unf_count", 32'(count), 32'd0);
      op(0, 0, 8'h00, 1);
      chk("unf_clr", 32'(underflow), 32'd0);
      op(0, 1, 8'h00, 1);
      chk("unf_prio", 32'(underflow), 32'd1);
      op(0, 0, 8'h00, 1);

      // tail call on non-empty stack
      op(1, 0, 8'h40, 0);
      op(1, 0, 8'h50, 0);
      op(1, 1, 8'h60, 0);
      chk("tail_top", 32'(topOut), 32'h60);
      chk("tail_count", 32'(count), 32'd2);
      chk("tail_flags", {30'd0, overflow, underflow}, 32'd0);
      op(0, 1, 8'h00, 0);
      chk("tail_pop_top", 32'(topOut), 32'h40);
      op(0, 1, 8'h00, 0);
      chk("tail_drain", 32'(empty), 32'd1);

      // push+pop on empty
      op(1, 1, 8'h7A, 0);
      chk("ep_count", 32'(count), 32'd1);
      chk("ep_top", 32'(topOut), 32'h7A);
      chk("ep_unf", 32'(underflow), 32'd1);

      // asynchronous reset between edges, then push ignored while reset high
      op(1, 0, 8'h10, 0);
      op(1, 0, 8'h20, 0);
      chk("pre_rst_count", 32'(count), 32'd3);
      #2;
      reset = 1'b1;
      #1;
      chk("arst_count", 32'(count), 32'd0);
      chk("arst_top", 32'(topOut), 32'h00);
      chk("arst_flags", {30'd0, overflow, underflow}, 32'd0);
      chk("arst_empty", 32'(empty), 32'd1);
      op(1, 0, 8'h55, 0);
      chk("rst_push_ign", 32'(count), 32'd0);
      @(negedge clock);
      reset = 1'b0;
      op(1, 0, 8'hA5, 0);
      chk("post_rst_top", 32'(topOut), 32'hA5);
      chk("post_rst_count", 32'(count), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
